advanced_fifo_controller: RTL
=============================

// Module: advanced_fifo_controller
//
// PURPOSE
// - Synchronous FIFO controller for an external memory; next generation of the basic controller.
// - Supports any DEPTH >= 2, not only powers of two. Adds occupancy level and runtime almost-full/almost-empty thresholds.
// - Adds guarded accesses, sticky overflow/underflow flags and a synchronous flush.
// - Sits between a producer/consumer pair and a 1R1W RAM/register file in the buffering datapath.
//
// PARAMETERS
// - WIDTH       8                  data width in bits
// - DEPTH       4                  number of entries, any integer >= 2
// - DEPTH_LOG2  `CLOG2(DEPTH)      memory address width
// - LEVEL_WIDTH `CLOG2(DEPTH+1)    width of the level and threshold values
//
// PORTS
// - clock                   in   1            clock, rising edge
// - resetn                  in   1            asynchronous reset, active-low
// - flush                   in   1            synchronous empty-the-queue request
// - clear_errors            in   1            clears the sticky error flags
// - almost_full_threshold   in   LEVEL_WIDTH  almost_full asserts when level >= this value
// - almost_empty_threshold  in   LEVEL_WIDTH  almost_empty asserts when level <= this value
// - full / empty            out  1            queue status
// - almost_full / almost_empty  out 1         threshold status
// - level                   out  LEVEL_WIDTH  number of stored entries, 0..DEPTH
// - overflow / underflow    out  1            sticky: write while full / read while empty
// - write_enable            in   1            write request
// - write_data              in   WIDTH        write data
// - read_enable             in   1            read request
// - read_data               out  WIDTH        = memory_read_data (combinational pass-through)
// - memory_write_enable     out  1            = accepted write
// - memory_write_address    out  DEPTH_LOG2   write pointer address
// - memory_write_data       out  WIDTH        = write_data
// - memory_read_enable      out  1            = accepted read
// - memory_read_address     out  DEPTH_LOG2   read pointer address
// - memory_read_data        in   WIDTH        memory read data
//
// BEHAVIOUR
// - Reset (async): pointers, lap bits and level = 0; overflow and underflow = 0.
//   Resulting outputs: empty=1, full=0, memory enables=0.
// - Pointers: address plus lap bit. Increment from DEPTH-1 wraps to 0 and toggles the lap bit.
//   No power-of-two arithmetic is used.
// - Status: empty = (addresses equal && laps equal); full = (addresses equal && laps differ).
// - Write accepted = write_enable && !full. Read accepted = read_enable && !empty.
//   Full/empty are evaluated before the current cycle's accesses.
// - Write while full is dropped and sets overflow. Read while empty is dropped and sets underflow.
// - Simultaneous accepted read and write: both pointers advance and level is unchanged.
// - Level register: +1 on write only, -1 on read only; never leaves the range 0..DEPTH.
// - Thresholds are combinational compares against the registered level.
//   Example: threshold 0 makes almost_full constant 1.
// - Read latency is set by the memory; the controller adds no registers on the data path.
// - flush: next cycle pointers and level = 0, so empty=1.
//   Accesses in the flush cycle: memory enables forced to 0, no error flags set.
//   Error flags are not cleared by flush.
// - clear_errors: flags clear next cycle. A new error in the same cycle wins, so the flag stays 1.
// - Reset asserted mid-operation: the queue is lost and all state returns to reset values immediately.
//
// CONFIGURATION
// - ADVANCED_FIFO_CONTROLLER_PEAK_LEVEL_EN
//   - Defined: adds output peak_level [LEVEL_WIDTH], a high-water mark.
//     Register updates to max(peak_level, next level). Reset to 0; cleared by clear_errors.
//     flush does not clear it.
//   - Undefined: port and logic are absent; all other behaviour is identical.
//
// TESTING
// - DEPTH=5, WIDTH=8: write 5 values -> full=1, level=5; read 5 -> same data in order, empty=1.
// - DEPTH=5: 12 interleaved write/read pairs -> addresses wrap 4->0, data intact, level stays 0/1.
// - Full queue, write_enable=1 -> memory_write_enable=0, overflow=1; read on empty -> underflow=1;
//   clear_errors -> both flags 0 next cycle.
// - Full queue, simultaneous read+write -> only the read is accepted, level 5->4.
//   Level 2, simultaneous read+write -> level stays 2.
// - Thresholds AF=4, AE=1 on DEPTH=5 -> almost_full asserts at level 4, almost_empty deasserts at level 2.
// - Level 3 then flush with write_enable=1 -> no memory write, next cycle level=0 and empty=1.
//   With the macro defined, peak_level stays 3.

Source files
------------

// File: rtl/advanced_fifo_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : advanced_fifo_controller_if
//  Description : Producer/consumer request bus plus 1R1W memory bus of the
//                advanced FIFO controller.
//                  write_enable / write_data   : producer write request
//                  read_enable  / read_data    : consumer read request / data
//                  memory_*                    : external 1R1W RAM port
//                Modport master is the controller's view (it drives the
//                memory bus and read_data); modport slave is the view of the
//                surrounding producer, consumer and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface advanced_fifo_controller_if #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
);
    logic                  write_enable;
    logic [WIDTH-1:0]      write_data;
    logic                  read_enable;
    logic [WIDTH-1:0]      read_data;
    logic                  memory_write_enable;
    logic [DEPTH_LOG2-1:0] memory_write_address;
    logic [WIDTH-1:0]      memory_write_data;
    logic                  memory_read_enable;
    logic [DEPTH_LOG2-1:0] memory_read_address;
    logic [WIDTH-1:0]      memory_read_data;

    modport master (
        input  write_enable,
        input  write_data,
        input  read_enable,
        input  memory_read_data,
        output read_data,
        output memory_write_enable,
        output memory_write_address,
        output memory_write_data,
        output memory_read_enable,
        output memory_read_address
    );

    modport slave (
        output write_enable,
        output write_data,
        output read_enable,
        output memory_read_data,
        input  read_data,
        input  memory_write_enable,
        input  memory_write_address,
        input  memory_write_data,
        input  memory_read_enable,
        input  memory_read_address
    );
endinterface
`default_nettype wire

// File: rtl/advanced_fifo_controller.sv
`default_nettype none
// ============================================================================
//  Module      : advanced_fifo_controller
//  Description : Synchronous FIFO controller for an external 1R1W memory.
//                Any DEPTH >= 2, occupancy level, runtime almost-full /
//                almost-empty thresholds, guarded accesses, sticky
//                overflow/underflow flags and a synchronous flush.
//  Ports       : clock, resetn (async, active-low)
//                flush, clear_errors, almost_*_threshold      (inputs)
//                full, empty, almost_full, almost_empty, level,
//                overflow, underflow                          (outputs)
//                peak_level (only with ADVANCED_FIFO_CONTROLLER_PEAK_LEVEL_EN)
//                fifo_bus : advanced_fifo_controller_if.master
//  Options     : `define ADVANCED_FIFO_CONTROLLER_PEAK_LEVEL_EN adds the
//                peak_level high-water-mark output.
//  Revision    : 1.0 - initial release
// ============================================================================
module advanced_fifo_controller #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int DEPTH_LOG2  = $clog2(DEPTH),
    parameter int LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
    input  wire logic                   clock,
    input  wire logic                   resetn,
    input  wire logic                   flush,
    input  wire logic                   clear_errors,
    input  wire logic [LEVEL_WIDTH-1:0] almost_full_threshold,
    input  wire logic [LEVEL_WIDTH-1:0] almost_empty_threshold,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [LEVEL_WIDTH-1:0]      level,
    output logic                        overflow,
    output logic                        underflow,
`ifdef ADVANCED_FIFO_CONTROLLER_PEAK_LEVEL_EN
    output logic [LEVEL_WIDTH-1:0]      peak_level,
`endif
    advanced_fifo_controller_if.master  fifo_bus
);

    localparam logic [DEPTH_LOG2-1:0]  c_LAST_ADDR = DEPTH_LOG2'(DEPTH - 1);
    localparam logic [DEPTH_LOG2-1:0]  c_ADDR_ONE  = DEPTH_LOG2'(1);
    localparam logic [LEVEL_WIDTH-1:0] c_LEVEL_ONE = LEVEL_WIDTH'(1);

    logic [DEPTH_LOG2-1:0]  r_wr_addr, r_rd_addr;
    logic                   r_wr_lap, r_rd_lap;
    logic [LEVEL_WIDTH-1:0] r_level;
    logic                   r_overflow, r_underflow;

    logic [DEPTH_LOG2-1:0]  w_wr_addr_next, w_rd_addr_next;
    logic                   w_wr_lap_next, w_rd_lap_next;
    logic [LEVEL_WIDTH-1:0] w_level_next;
    logic                   w_write_accept, w_read_accept;
    logic                   w_overflow_event, w_underflow_event;
    logic                   w_addr_equal;

    // Status comes from the pointers as they stand before this cycle's accesses.
    assign w_addr_equal = (r_wr_addr == r_rd_addr);
    assign empty        = w_addr_equal && (r_wr_lap == r_rd_lap);
    assign full         = w_addr_equal && (r_wr_lap != r_rd_lap);

    // A flush cycle suppresses both accesses and any error they would raise.
    assign w_write_accept    = fifo_bus.write_enable && !full  && !flush;
    assign w_read_accept     = fifo_bus.read_enable  && !empty && !flush;
    assign w_overflow_event  = fifo_bus.write_enable &&  full  && !flush;
    assign w_underflow_event = fifo_bus.read_enable  &&  empty && !flush;

    assign fifo_bus.memory_write_enable  = w_write_accept;
    assign fifo_bus.memory_write_address = r_wr_addr;
    assign fifo_bus.memory_write_data    = fifo_bus.write_data;
    assign fifo_bus.memory_read_enable   = w_read_accept;
    assign fifo_bus.memory_read_address  = r_rd_addr;
    assign fifo_bus.read_data            = fifo_bus.memory_read_data;

    // Explicit wrap at DEPTH-1 keeps non-power-of-two depths correct; the lap
    // bit distinguishes full from empty when the addresses coincide.
    always_comb begin
        w_wr_addr_next = r_wr_addr;
        w_wr_lap_next  = r_wr_lap;
        if (w_write_accept) begin
            if (r_wr_addr == c_LAST_ADDR) begin
                w_wr_addr_next = '0;
                w_wr_lap_next  = ~r_wr_lap;
            end else begin
                w_wr_addr_next = r_wr_addr + c_ADDR_ONE;
            end
        end
    end

    always_comb begin
        w_rd_addr_next = r_rd_addr;
        w_rd_lap_next  = r_rd_lap;
        if (w_read_accept) begin
            if (r_rd_addr == c_LAST_ADDR) begin
                w_rd_addr_next = '0;
                w_rd_lap_next  = ~r_rd_lap;
            end else begin
                w_rd_addr_next = r_rd_addr + c_ADDR_ONE;
            end
        end
    end

    always_comb begin
        w_level_next = r_level;
        if (flush) begin
            w_level_next = '0;
        end else if (w_write_accept && !w_read_accept) begin
            w_level_next = r_level + c_LEVEL_ONE;
        end else if (w_read_accept && !w_write_accept) begin
            w_level_next = r_level - c_LEVEL_ONE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_addr <= '0;
            r_wr_lap  <= 1'b0;
            r_rd_addr <= '0;
            r_rd_lap  <= 1'b0;
            r_level   <= '0;
        end else if (flush) begin
            r_wr_addr <= '0;
            r_wr_lap  <= 1'b0;
            r_rd_addr <= '0;
            r_rd_lap  <= 1'b0;
            r_level   <= '0;
        end else begin
            r_wr_addr <= w_wr_addr_next;
            r_wr_lap  <= w_wr_lap_next;
            r_rd_addr <= w_rd_addr_next;
            r_rd_lap  <= w_rd_lap_next;
            r_level   <= w_level_next;
        end
    end

    // A fresh error in the same cycle as clear_errors keeps the flag set.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_overflow_event) begin
                r_overflow <= 1'b1;
            end else if (clear_errors) begin
                r_overflow <= 1'b0;
            end
            if (w_underflow_event) begin
                r_underflow <= 1'b1;
            end else if (clear_errors) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign almost_full  = (r_level >= almost_full_threshold);
    assign almost_empty = (r_level <= almost_empty_threshold);

`ifdef ADVANCED_FIFO_CONTROLLER_PEAK_LEVEL_EN
    logic [LEVEL_WIDTH-1:0] r_peak_level;

    // Tracks the level the queue is about to hold, so it never lags level.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_peak_level <= '0;
        end else if (clear_errors) begin
            r_peak_level <= '0;
        end else if (w_level_next > r_peak_level) begin
            r_peak_level <= w_level_next;
        end
    end

    assign peak_level = r_peak_level;
`else
    // No high-water mark in this build.
`endif

endmodule
`default_nettype wire
